// File: rtl/change_dispenser.sv
// Change dispenser: pays a refund amount as coins, largest first, one per valid/ack handshake.
// Optional coin inventory (stock counters and refill port) is enabled by CHANGE_DISPENSER_INVENTORY_EN.
module change_dispenser #(
  parameter int TOTAL_BITS = 31,
  parameter int COIN0_VAL  = 100,
  parameter int COIN1_VAL  = 500,
  parameter int COIN2_VAL  = 1000
`ifdef CHANGE_DISPENSER_INVENTORY_EN
  ,
  parameter int STOCK_BITS = 8,
  parameter int STOCK_INIT = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [TOTAL_BITS-1:0] i_amount,
  input  logic                  i_coin_ack,
`ifdef CHANGE_DISPENSER_INVENTORY_EN
  input  logic                  i_refill,
  input  logic [1:0]            i_refill_kind,
  input  logic [STOCK_BITS-1:0] i_refill_num,
`endif
  output logic                  o_ready,
  output logic [2:0]            o_return_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [TOTAL_BITS-1:0] o_remaining
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  localparam logic [TOTAL_BITS-1:0] C0 = TOTAL_BITS'(COIN0_VAL);
  localparam logic [TOTAL_BITS-1:0] C1 = TOTAL_BITS'(COIN1_VAL);
  localparam logic [TOTAL_BITS-1:0] C2 = TOTAL_BITS'(COIN2_VAL);

  logic [1:0]            state_r;
  logic [TOTAL_BITS-1:0] remaining_r;
  logic                  error_r;
  logic [2:0]            coin_s;
  logic [TOTAL_BITS-1:0] coin_val_s;
  logic [TOTAL_BITS-1:0] rem_next_s;
  logic [2:0]            has_stock_s;

`ifdef CHANGE_DISPENSER_INVENTORY_EN
  logic [STOCK_BITS-1:0] stock_r [3];

  assign has_stock_s = {stock_r[2] != '0, stock_r[1] != '0, stock_r[0] != '0};

  // Stock counters: an acked coin is consumed; a refill (IDLE only) loads the count,
  // so the counter can never pass its maximum.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stock_r[0] <= STOCK_BITS'(STOCK_INIT);
      stock_r[1] <= STOCK_BITS'(STOCK_INIT);
      stock_r[2] <= STOCK_BITS'(STOCK_INIT);
    end else if (state_r == ST_DISPENSE && i_coin_ack) begin
      case (coin_s)
        3'b001:  stock_r[0] <= stock_r[0] - STOCK_BITS'(1);
        3'b010:  stock_r[1] <= stock_r[1] - STOCK_BITS'(1);
        3'b100:  stock_r[2] <= stock_r[2] - STOCK_BITS'(1);
        default: stock_r[0] <= stock_r[0];
      endcase
    end else if (state_r == ST_IDLE && i_refill) begin
      case (i_refill_kind)
        2'd0:    stock_r[0] <= i_refill_num;
        2'd1:    stock_r[1] <= i_refill_num;
        2'd2:    stock_r[2] <= i_refill_num;
        default: stock_r[0] <= stock_r[0];
      endcase
    end else begin
      stock_r[0] <= stock_r[0];
    end
  end
`else
  assign has_stock_s = 3'b111;
`endif

  // Largest affordable (and stocked) coin, presented only while dispensing.
  always_comb begin
    coin_s = 3'b000;
    if (state_r == ST_DISPENSE) begin
      if (remaining_r >= C2 && has_stock_s[2])      coin_s = 3'b100;
      else if (remaining_r >= C1 && has_stock_s[1]) coin_s = 3'b010;
      else if (remaining_r >= C0 && has_stock_s[0]) coin_s = 3'b001;
      else                                          coin_s = 3'b000;
    end else begin
      coin_s = 3'b000;
    end
  end

  // Value of the presented coin; never exceeds remaining, so the subtraction cannot wrap.
  always_comb begin
    coin_val_s = '0;
    case (coin_s)
      3'b100:  coin_val_s = C2;
      3'b010:  coin_val_s = C1;
      3'b001:  coin_val_s = C0;
      default: coin_val_s = '0;
    endcase
  end

  assign rem_next_s = remaining_r - coin_val_s;

  // Refund FSM with balance and error tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      remaining_r <= '0;
      error_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            remaining_r <= i_amount;
            if (i_amount >= C0) begin
              state_r <= ST_DISPENSE;
              error_r <= 1'b0;
            end else begin
              state_r <= ST_DONE;
              error_r <= (i_amount != '0);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DISPENSE: begin
          if (coin_s == 3'b000) begin
            // Nothing stocked fits the balance: give up with the balance unpaid.
            state_r <= ST_DONE;
            error_r <= (remaining_r != '0);
          end else if (i_coin_ack) begin
            remaining_r <= rem_next_s;
            if (rem_next_s < C0) begin
              state_r <= ST_DONE;
              error_r <= (rem_next_s != '0);
            end else begin
              state_r <= ST_DISPENSE;
            end
          end else begin
            state_r <= ST_DISPENSE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready       = (state_r == ST_IDLE);
  assign o_busy        = (state_r == ST_DISPENSE) || (state_r == ST_DONE);
  assign o_done        = (state_r == ST_DONE);
  assign o_return_coin = coin_s;
  assign o_error       = error_r;
  assign o_remaining   = remaining_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser (default build): vector table, random refunds
// against a greedy-arithmetic reference model, and hand-written corner sequences.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic [30:0] i_amount;
  logic        i_coin_ack;
  logic        o_ready;
  logic [2:0]  o_return_coin;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [30:0] o_remaining;

  int n_checks = 0;
  int n_fail   = 0;

  change_dispenser dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_amount     (i_amount),
    .i_coin_ack   (i_coin_ack),
    .o_ready      (o_ready),
    .o_return_coin(o_return_coin),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_remaining  (o_remaining)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] coin_value(input logic [2:0] c);
    case (c)
      3'b100:  return 32'd1000;
      3'b010:  return 32'd500;
      3'b001:  return 32'd100;
      default: return 32'd0;
    endcase
  endfunction

  // Reference: greedy change with unlimited stock, computed by division.
  task automatic model(input logic [30:0] amt, output logic [2:0] coins[$], output logic [31:0] left);
    int unsigned a;
    a = 32'(amt);
    coins = {};
    for (int k = 0; k < int'(a / 1000); k++) coins.push_back(3'b100);
    a = a % 1000;
    for (int k = 0; k < int'(a / 500); k++) coins.push_back(3'b010);
    a = a % 500;
    for (int k = 0; k < int'(a / 100); k++) coins.push_back(3'b001);
    left = 32'(a % 100);
  endtask

  task automatic refund(input logic [30:0] amt, input int stall_pct,
                        output int ncoins, output logic [31:0] rem_out, output logic err_out);
    logic [2:0]  q[$];
    logic [31:0] left;
    logic [31:0] exp_rem;
    logic        ack;
    int          budget;
    model(amt, q, left);
    exp_rem = 32'(amt);
    ncoins  = 0;
    budget  = 0;
    chk("ready_before_start", 32'(o_ready), 32'd1);
    i_start    = 1'b1;
    i_amount   = amt;
    i_coin_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (q.size() != 0 && budget < 2000) begin
      chk("coin", 32'(o_return_coin), 32'(q[0]));
      chk("busy_dispense", 32'(o_busy), 32'd1);
      chk("remaining_mid", 32'(o_remaining), exp_rem);
      i_start  = 1'($urandom_range(0, 1));
      i_amount = 31'($urandom);
      ack = ($urandom_range(0, 99) >= 32'(stall_pct));
      i_coin_ack = ack;
      if (ack) begin
        exp_rem = exp_rem - coin_value(q[0]);
        void'(q.pop_front());
        ncoins++;
      end
      @(negedge clk);
      budget++;
    end
    if (budget >= 2000) chk("dispense_budget", 32'(budget), 32'd0);
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("coin_at_done", 32'(o_return_coin), 32'd0);
    chk("remaining_final", 32'(o_remaining), left);
    chk("error_final", 32'(o_error), 32'(left != 32'd0));
    rem_out = 32'(o_remaining);
    err_out = o_error;
    i_start    = 1'b0;
    i_coin_ack = 1'b1;
    @(negedge clk);
    chk("ready_after", 32'(o_ready), 32'd1);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("error_held", 32'(o_error), 32'(left != 32'd0));
    chk("coin_idle", 32'(o_return_coin), 32'd0);
    i_coin_ack = 1'b0;
  endtask

  typedef struct {
    logic [30:0] amount;
    int          coins;
    logic [31:0] rem;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  // Hard stop in case the DUT wedges the bench.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          nc;
    logic [31:0] r;
    logic        e;

    vecs[0] = '{31'd1600, 3, 32'd0,  1'b0};
    vecs[1] = '{31'd0,    0, 32'd0,  1'b0};
    vecs[2] = '{31'd250,  2, 32'd50, 1'b1};
    vecs[3] = '{31'd50,   0, 32'd50, 1'b1};
    vecs[4] = '{31'd100,  1, 32'd0,  1'b0};
    vecs[5] = '{31'd99,   0, 32'd99, 1'b1};
    vecs[6] = '{31'd1999, 6, 32'd99, 1'b1};
    vecs[7] = '{31'd3800, 7, 32'd0,  1'b0};
    vecs[8] = '{31'd500,  1, 32'd0,  1'b0};
    vecs[9] = '{31'd1,    0, 32'd1,  1'b1};

    reset_n    = 1'b0;
    i_start    = 1'b0;
    i_amount   = '0;
    i_coin_ack = 1'b0;
    #1;
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_done", 32'(o_done), 32'd0);
    chk("reset_error", 32'(o_error), 32'd0);
    chk("reset_coin", 32'(o_return_coin), 32'd0);
    chk("reset_remaining", 32'(o_remaining), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      refund(vecs[v].amount, 0, nc, r, e);
      chk("vec_coins", 32'(nc), 32'(vecs[v].coins));
      chk("vec_remaining", r, vecs[v].rem);
      chk("vec_error", 32'(e), 32'(vecs[v].err));
    end

    for (int t = 0; t < 40; t++) begin
      logic [30:0] amt;
      if (t % 2 == 0) amt = 31'($urandom_range(0, 200) * 50);
      else            amt = 31'($urandom_range(0, 12000));
      refund(amt, (t % 3) * 30, nc, r, e);
    end

    // Back-pressure: coin held for 5 stalled cycles while a second start is ignored.
    i_start  = 1'b1;
    i_amount = 31'd500;
    @(negedge clk);
    i_amount   = 31'd1600;
    i_coin_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_coin", 32'(o_return_coin), 32'd2);
      chk("bp_remaining", 32'(o_remaining), 32'd500);
      chk("bp_done_low", 32'(o_done), 32'd0);
      @(negedge clk);
    end
    i_start    = 1'b0;
    i_coin_ack = 1'b1;
    @(negedge clk);
    i_coin_ack = 1'b0;
    chk("bp_done", 32'(o_done), 32'd1);
    chk("bp_remaining_final", 32'(o_remaining), 32'd0);
    chk("bp_error", 32'(o_error), 32'd0);
    @(negedge clk);
    chk("bp_ready", 32'(o_ready), 32'd1);
    @(negedge clk);
    chk("bp_no_queued_start", 32'(o_busy), 32'd0);

    // Reset in the middle of a 3000 refund, asserted between clock edges.
    i_start  = 1'b1;
    i_amount = 31'd3000;
    @(negedge clk);
    i_start = 1'b0;
    chk("rst_first_coin", 32'(o_return_coin), 32'd4);
    i_coin_ack = 1'b1;
    @(negedge clk);
    i_coin_ack = 1'b0;
    chk("rst_second_coin", 32'(o_return_coin), 32'd4);
    chk("rst_remaining_mid", 32'(o_remaining), 32'd2000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_coin", 32'(o_return_coin), 32'd0);
    chk("rst_async_remaining", 32'(o_remaining), 32'd0);
    chk("rst_async_ready", 32'(o_ready), 32'd1);
    chk("rst_async_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    i_coin_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_reissue_coin", 32'(o_return_coin), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd1);
    end
    i_coin_ack = 1'b0;

    // Maximum amount: latched intact and decremented without wrap.
    i_start  = 1'b1;
    i_amount = 31'h7FFF_FFFF;
    @(negedge clk);
    i_start = 1'b0;
    chk("max_latched", 32'(o_remaining), 32'h7FFF_FFFF);
    chk("max_coin", 32'(o_return_coin), 32'd4);
    i_coin_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_coin_ack = 1'b0;
    chk("max_after_two", 32'(o_remaining), 32'h7FFF_FFFF - 32'd2000);
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    refund(31'd1600, 0, nc, r, e);
    chk("post_reset_coins", 32'(nc), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
